cfg_reg_ctrl: RTL

CFG_REG_CTRL -- requirements
Module: cfg_reg_ctrl

---
 rtl/cfg_reg_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cfg_reg_ctrl.sv
// Shadow/active config registers: 4-way round-robin write port (ready same cycle, shadow_q updates next cycle).
// Commits copy shadow->active in one edge, deferred while engine_busy; ready is the only backpressure.
module cfg_reg_ctrl #(
    parameter int              WIDTH     = 16,
    parameter int              NREG      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req_valid,
    input  logic [11:0]           req_addr,
    input  logic [4*WIDTH-1:0]    req_data,
    output logic [3:0]            req_ready,
    input  logic                  commit,
    input  logic                  engine_busy,
    output logic [NREG*WIDTH-1:0] shadow_q,
    output logic [NREG*WIDTH-1:0] active_q,
    output logic                  commit_pending,
    output logic                  commit_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic                    done_q, done_d;
    logic [NREG*WIDTH-1:0]   shadow_d, active_d;

    logic [2:0]              addr_a [4];
    logic [WIDTH-1:0]        data_a [4];
    logic                    gnt_vld;
    logic [1:0]              gnt_idx;
    logic [1:0]              idx;
    logic                    copy;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = req_addr[3*i +: 3];
            data_a[i] = req_data[WIDTH*i +: WIDTH];
        end
    end

    // Search starts at ptr and wraps; first valid requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < 4; i++) begin
            req_ready[i] = gnt_vld && !rst && (gnt_idx == 2'(i));
        end
    end

    always_comb begin
        ptr_d    = gnt_vld ? gnt_idx + 2'd1 : ptr_q;
        shadow_d = shadow_q;
        for (int n = 0; n < NREG; n++) begin
            if (gnt_vld && (addr_a[gnt_idx] == 3'(n))) begin
                shadow_d[n*WIDTH +: WIDTH] = data_a[gnt_idx];
            end
        end
    end

    // Copy uses shadow_q, so a write on the copy edge waits for the next commit.
    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    if (engine_busy) begin
                        state_d = ST_WAIT;
                    end else begin
                        copy = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!engine_busy) begin
                    copy    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        active_d = copy ? shadow_q : active_q;
        done_d   = copy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= {NREG{RESET_VAL}};
            active_q <= {NREG{RESET_VAL}};
            ptr_q    <= 2'd0;
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            ptr_q    <= ptr_d;
            state_q  <= state_d;
            done_q   <= done_d;
        end
    end

    assign commit_pending = (state_q == ST_WAIT);
    assign commit_done    = done_q;

endmodule
